// File: rtl/huff_pkg.sv
// Shared sizing, node record and FSM state type for the Huffman encoder.
package huff_pkg;

  localparam int MAX_STRING_LENGTH_DEF = 10;
  localparam int MAX_CHAR_COUNT_DEF    = 5;

  // Leaves occupy the low half of the node table, merged nodes the high half.
  localparam int NODE_COUNT = 2 * MAX_CHAR_COUNT_DEF;
  localparam int IDX_W      = $clog2(NODE_COUNT);

  // Input counts are 3 bits; five of them summed never exceed 35, so 6 bits suffice.
  localparam int IN_FREQ_W = 3;
  localparam int FREQ_W    = 6;

  // Holds a code length from 0 up to MAX_CHAR_COUNT, and also the leaf count.
  localparam int LEN_W = $clog2(MAX_CHAR_COUNT_DEF + 1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_SELECT = 3'd1,
    ST_MERGE  = 3'd2,
    ST_ENCODE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0]        symbol;
    logic [FREQ_W-1:0] freq;
    logic [IDX_W-1:0]  left;
    logic [IDX_W-1:0]  right;
    logic              leaf;
    logic              valid;
    logic              merged;
  } node_t;

  // Ones over the low 'len' bits of a code field.
  function automatic logic [MAX_CHAR_COUNT_DEF-1:0] len_to_mask(input logic [LEN_W-1:0] len);
    return ~({MAX_CHAR_COUNT_DEF{1'b1}} << len);
  endfunction

endpackage

// File: rtl/huff_min2.sv
// Finds the two lowest-frequency live (valid, unmerged) nodes.
// min_a_o is the smallest, min_b_o the runner-up; equal frequencies
// resolve toward the lower node index.
module huff_min2
  import huff_pkg::*;
#(
  parameter int N_NODES = NODE_COUNT
) (
  input  node_t            nodes_i [N_NODES],
  output logic [IDX_W-1:0] min_a_o,
  output logic [IDX_W-1:0] min_b_o
);

  logic              have_a;
  logic              have_b;
  logic [FREQ_W-1:0] freq_a;
  logic [FREQ_W-1:0] freq_b;

  // Ascending scan with strict compares, so an earlier index keeps its place on ties
  always_comb begin
    have_a  = 1'b0;
    have_b  = 1'b0;
    freq_a  = '0;
    freq_b  = '0;
    min_a_o = '0;
    min_b_o = '0;
    for (int j = 0; j < N_NODES; j++) begin
      if (nodes_i[j].valid && !nodes_i[j].merged) begin
        if (!have_a || (nodes_i[j].freq < freq_a)) begin
          min_b_o = min_a_o;
          freq_b  = freq_a;
          have_b  = have_a;
          min_a_o = IDX_W'(j);
          freq_a  = nodes_i[j].freq;
          have_a  = 1'b1;
        end else if (!have_b || (nodes_i[j].freq < freq_b)) begin
          min_b_o = IDX_W'(j);
          freq_b  = nodes_i[j].freq;
          have_b  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/huffman_encoder.sv
// Run-once Huffman encoder: loads a symbol/frequency table after reset,
// merges nodes one pair per SELECT/MERGE round, then derives an MSB-first
// prefix code and valid-bit mask per input slot and raises a sticky done.
// The node record is sized from the huff_pkg defaults, so the parameters
// must not exceed those defaults.
module huffman_encoder
  import huff_pkg::*;
#(
  parameter int MAX_STRING_LENGTH = MAX_STRING_LENGTH_DEF,
  parameter int MAX_CHAR_COUNT    = MAX_CHAR_COUNT_DEF
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [MAX_STRING_LENGTH-1:0][7:0]             data_in,
  input  logic [MAX_STRING_LENGTH-1:0][IN_FREQ_W-1:0]   freq_in,
  output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] encoded_value,
  output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] encoded_mask,
  output logic                                          done
);

  localparam int N_NODES = 2 * MAX_CHAR_COUNT;

  state_e                                        state_q;
  state_e                                        state_d;
  node_t                                         node_q [N_NODES];
  logic [IDX_W-1:0]                              left_q;
  logic [IDX_W-1:0]                              right_q;
  logic [IDX_W-1:0]                              merge_cnt_q;
  logic [LEN_W-1:0]                              remaining_q;
  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] value_q;
  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] mask_q;
  logic                                          done_q;

  logic [MAX_CHAR_COUNT-1:0] leaf_ok;
  logic [LEN_W-1:0]          leaf_cnt;
  logic [IDX_W-1:0]          min_a;
  logic [IDX_W-1:0]          min_b;
  logic [IDX_W-1:0]          merge_idx;
  logic [MAX_CHAR_COUNT-1:0] code_w [N_NODES];
  logic [LEN_W-1:0]          len_w  [N_NODES];

  // A slot becomes a leaf only when both its byte and its count are nonzero
  for (genvar gi = 0; gi < MAX_CHAR_COUNT; gi++) begin : g_leaf
    assign leaf_ok[gi] = (data_in[gi] != 8'h00) && (freq_in[gi] != '0);
  end

  // Slots beyond MAX_CHAR_COUNT are deliberately ignored
  if (MAX_STRING_LENGTH > MAX_CHAR_COUNT) begin : g_spare
    logic unused_spare_slots;
    assign unused_spare_slots = ^{data_in[MAX_STRING_LENGTH-1:MAX_CHAR_COUNT],
                                  freq_in[MAX_STRING_LENGTH-1:MAX_CHAR_COUNT]};
  end

  assign leaf_cnt  = LEN_W'($countones(leaf_ok));
  assign merge_idx = IDX_W'(MAX_CHAR_COUNT) + merge_cnt_q;

  huff_min2 #(
    .N_NODES (N_NODES)
  ) u_min2 (
    .nodes_i (node_q),
    .min_a_o (min_a),
    .min_b_o (min_b)
  );

  // Top-down code walk: parents always sit above their children, so a descending scan sees each parent's code first
  always_comb begin
    for (int j = 0; j < N_NODES; j++) begin
      code_w[j] = '0;
      len_w[j]  = '0;
    end
    for (int p = N_NODES - 1; p >= MAX_CHAR_COUNT; p--) begin
      if (node_q[p].valid) begin
        code_w[node_q[p].left]  = {code_w[p][MAX_CHAR_COUNT-2:0], 1'b0};
        len_w[node_q[p].left]   = len_w[p] + 1'b1;
        code_w[node_q[p].right] = {code_w[p][MAX_CHAR_COUNT-2:0], 1'b1};
        len_w[node_q[p].right]  = len_w[p] + 1'b1;
      end
    end
  end

  // Next-state: zero or one leaf skips tree building; the last merge leaves a single live root
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = (leaf_cnt <= LEN_W'(1)) ? ST_ENCODE : ST_SELECT;
      ST_SELECT: state_d = ST_MERGE;
      ST_MERGE:  state_d = (remaining_q == LEN_W'(2)) ? ST_ENCODE : ST_SELECT;
      ST_ENCODE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_INIT;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Node table, pair selection, merge bookkeeping and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < N_NODES; j++) begin
        node_q[j] <= '0;
      end
      left_q      <= '0;
      right_q     <= '0;
      merge_cnt_q <= '0;
      remaining_q <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          for (int j = 0; j < N_NODES; j++) begin
            node_q[j] <= '0;
          end
          for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
            if (leaf_ok[i]) begin
              node_q[i] <= '{symbol: data_in[i],
                             freq:   FREQ_W'(freq_in[i]),
                             left:   '0,
                             right:  '0,
                             leaf:   1'b1,
                             valid:  1'b1,
                             merged: 1'b0};
            end
          end
          merge_cnt_q <= '0;
          remaining_q <= leaf_cnt;
          value_q     <= '0;
          mask_q      <= '0;
          done_q      <= 1'b0;
        end
        ST_SELECT: begin
          left_q  <= min_a;
          right_q <= min_b;
        end
        ST_MERGE: begin
          node_q[merge_idx] <= '{symbol: 8'h00,
                                 freq:   node_q[left_q].freq + node_q[right_q].freq,
                                 left:   left_q,
                                 right:  right_q,
                                 leaf:   1'b0,
                                 valid:  1'b1,
                                 merged: 1'b0};
          node_q[left_q].merged  <= 1'b1;
          node_q[right_q].merged <= 1'b1;
          merge_cnt_q <= merge_cnt_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
        end
        ST_ENCODE: begin
          for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
            if (node_q[i].valid && node_q[i].leaf) begin
              value_q[i] <= code_w[i];
              mask_q[i]  <= len_to_mask(len_w[i]);
            end else begin
              value_q[i] <= '0;
              mask_q[i]  <= '0;
            end
          end
          done_q <= 1'b1;
        end
        default: begin
          // ST_DONE holds everything until the next reset
        end
      endcase
    end
  end

  assign encoded_value = value_q;
  assign encoded_mask  = mask_q;
  assign done          = done_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder: hand-computed codes per case,
// latency bounds, async reset clearing and post-done hold.
module tb_huffman_encoder;

  localparam int MSL = 10;
  localparam int MCC = 5;

  logic                    clk;
  logic                    reset;
  logic [MSL-1:0][7:0]     data_in;
  logic [MSL-1:0][2:0]     freq_in;
  logic [MCC-1:0][MCC-1:0] encoded_value;
  logic [MCC-1:0][MCC-1:0] encoded_mask;
  logic                    done;

  int checks;
  int errors;

  logic [MCC-1:0][MCC-1:0] ev;
  logic [MCC-1:0][MCC-1:0] em;

  huffman_encoder dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .freq_in       (freq_in),
    .encoded_value (encoded_value),
    .encoded_mask  (encoded_mask),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_codes(input string tag);
    for (int i = 0; i < MCC; i++) begin
      check($sformatf("%s val%0d", tag, i), 32'(encoded_value[i]), 32'(ev[i]));
      check($sformatf("%s mask%0d", tag, i), 32'(encoded_mask[i]), 32'(em[i]));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " done"},  32'(done), 32'd0);
    check({tag, " value"}, 32'(encoded_value), 32'd0);
    check({tag, " mask"},  32'(encoded_mask), 32'd0);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Counts clocks from the first edge after release; done must be low on
  // cycle 1 and high no later than 'bound'.
  task automatic run_to_done(input string tag, input int bound);
    int cyc;
    @(posedge clk);
    #1;
    cyc = 1;
    check({tag, " early done"}, 32'(done), 32'd0);
    while ((cyc < bound) && (done !== 1'b1)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " done by bound"}, 32'(done), 32'd1);
    $display("case %s: done seen after %0d cycles (bound %0d)", tag, cyc, bound);
  endtask

  task automatic clear_inputs();
    data_in = '0;
    freq_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk    = 1'b0;
    reset  = 1'b0;
    checks = 0;
    errors = 0;
    clear_inputs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    $display("case reset: outputs sampled during reset");

    // 'a','n','u' with counts 1,2,1
    clear_inputs();
    data_in[0] = 8'h61; freq_in[0] = 3'd1;
    data_in[1] = 8'h6E; freq_in[1] = 3'd2;
    data_in[2] = 8'h75; freq_in[2] = 3'd1;
    release_reset();
    run_to_done("anu", 6);
    ev = '0; em = '0;
    ev[0] = 5'b00010; em[0] = 5'b00011;
    ev[1] = 5'b00000; em[1] = 5'b00001;
    ev[2] = 5'b00011; em[2] = 5'b00011;
    check_codes("anu");

    // 'a','b' with equal counts: lower slot takes the 0 branch
    enter_reset();
    clear_inputs();
    data_in[0] = 8'h61; freq_in[0] = 3'd2;
    data_in[1] = 8'h62; freq_in[1] = 3'd2;
    release_reset();
    run_to_done("ab", 5);
    ev = '0; em = '0;
    ev[0] = 5'b00000; em[0] = 5'b00001;
    ev[1] = 5'b00001; em[1] = 5'b00001;
    check_codes("ab");

    // Single symbol, plus a zero-count slot, a zero-byte slot and an out-of-range slot
    enter_reset();
    clear_inputs();
    data_in[0] = 8'h61; freq_in[0] = 3'd3;
    data_in[1] = 8'h62; freq_in[1] = 3'd0;
    data_in[2] = 8'h00; freq_in[2] = 3'd5;
    data_in[7] = 8'h7A; freq_in[7] = 3'd7;
    release_reset();
    run_to_done("single", 4);
    ev = '0; em = '0;
    check_codes("single");

    // Five symbols, all count 1
    enter_reset();
    clear_inputs();
    for (int i = 0; i < MCC; i++) begin
      data_in[i] = 8'h61 + 8'(i);
      freq_in[i] = 3'd1;
    end
    release_reset();
    run_to_done("five", 11);
    ev = '0; em = '0;
    ev[0] = 5'b00110; em[0] = 5'b00111;
    ev[1] = 5'b00111; em[1] = 5'b00111;
    ev[2] = 5'b00000; em[2] = 5'b00011;
    ev[3] = 5'b00001; em[3] = 5'b00011;
    ev[4] = 5'b00010; em[4] = 5'b00011;
    check_codes("five");

    // Reset asserted between clock edges must clear populated outputs at once
    #2;
    reset = 1'b0;
    #1;
    check_cleared("async clear");
    $display("case async clear: reset asserted off-edge after done");

    // Reset asserted while the five-symbol run sits in MERGE, then a new table
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    #2;
    reset = 1'b0;
    #1;
    check_cleared("mid merge");
    $display("case mid merge: reset asserted during second cycle of run");
    clear_inputs();
    data_in[0] = 8'h78; freq_in[0] = 3'd1;
    data_in[1] = 8'h79; freq_in[1] = 3'd3;
    release_reset();
    run_to_done("xy", 5);
    ev = '0; em = '0;
    ev[0] = 5'b00000; em[0] = 5'b00001;
    ev[1] = 5'b00001; em[1] = 5'b00001;
    check_codes("xy");

    // Outputs and done hold for 20 cycles while the inputs change
    clear_inputs();
    data_in[0] = 8'h70; freq_in[0] = 3'd3;
    data_in[1] = 8'h71; freq_in[1] = 3'd2;
    data_in[2] = 8'h72; freq_in[2] = 3'd1;
    data_in[3] = 8'h73; freq_in[3] = 3'd7;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold done c%0d", c),  32'(done), 32'd1);
      check($sformatf("hold value c%0d", c), 32'(encoded_value), 32'(ev));
      check($sformatf("hold mask c%0d", c),  32'(encoded_mask), 32'(em));
    end
    $display("case hold: 20 cycles after done with altered inputs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
